// File: rtl/sr_sched_pkg.sv
// Shared encodings for the queue-array command sequencer: scheduler opcodes,
// controller FSM states and default field widths.
package sr_sched_pkg;

    localparam int TID_W_DEF  = 4;
    localparam int INFO_W_DEF = 32;

    typedef enum logic [1:0] {
        OP_ENQ      = 2'b00,
        OP_DEQ      = 2'b01,
        OP_REMOVE   = 2'b10,
        OP_SETSTATE = 2'b11
    } CmdOp;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_EXEC   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_RESP   = 3'd3,
        ST_TICK   = 3'd4
    } CtrlState;

endpackage

// File: rtl/sr_tick_prescaler.sv
// Time-slice prescaler: free-running 0..TICK_DIV-1 counter that raises a sticky
// tick request on every wrap until the controller consumes it.
module sr_tick_prescaler #(
    parameter int TICK_DIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    output logic o_tickPend
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_tickPend;
    logic             w_wrap;

    assign w_wrap     = (r_cnt == CNT_MAX);
    assign o_tickPend = r_tickPend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // A wrap coinciding with the consume of the previous tick starts a new
    // request, so a tick is never lost; extra wraps while pending merge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tickPend <= 1'b0;
        end else if (w_wrap) begin
            r_tickPend <= 1'b1;
        end else if (i_clear) begin
            r_tickPend <= 1'b0;
        end
    end

endmodule

// File: rtl/sr_queue_ctrl.sv
// Command sequencer for the shift-register task queue array: accepts one
// scheduler command at a time, strobes the array, then responds after it settles.
module sr_queue_ctrl
    import sr_sched_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int TID_W    = TID_W_DEF,
    parameter int INFO_W   = INFO_W_DEF,
    parameter int TICK_DIV = 1000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_op,
    input  logic [TID_W-1:0]           cmd_tid,
    input  logic [INFO_W-1:0]          cmd_info,
    output logic                       q_enqueue,
    output logic                       q_dequeue,
    output logic                       q_remove,
    output logic                       q_tick,
    output logic                       q_act,
    output logic                       q_blk,
    output logic [TID_W-1:0]           q_tid,
    output logic [INFO_W-1:0]          q_data,
    input  logic [TID_W-1:0]           head_tid,
    input  logic [INFO_W-1:0]          head_info,
    output logic                       rsp_valid,
    output logic                       rsp_err,
    output logic [TID_W-1:0]           rsp_tid,
    output logic [INFO_W-1:0]          rsp_info,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int MAP_W = 1 << TID_W;

    CtrlState            r_state;
    CtrlState            w_stateNext;
    CmdOp                r_op;
    logic [TID_W-1:0]    r_tid;
    logic [INFO_W-1:0]   r_info;
    logic [MAP_W-1:0]    r_tidMap;
    logic [CNT_W-1:0]    r_count;
    logic                r_act;
    logic                r_err;
    logic [TID_W-1:0]    r_rspTid;
    logic [INFO_W-1:0]   r_rspInfo;

    logic                w_tickPend;
    logic                w_tickClear;
    logic                w_handshake;
    logic                w_full;
    logic                w_empty;
    logic                w_resident;
    logic                w_legal;
    logic                w_inExec;
    logic                w_doEnq;
    logic                w_doDeq;
    logic                w_doRem;
    logic                w_doSet;

    sr_tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (w_tickClear),
        .o_tickPend (w_tickPend)
    );

    assign w_full      = (r_count == CNT_W'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_resident  = r_tidMap[r_tid];
    assign cmd_ready   = (r_state == ST_IDLE) && !w_tickPend;
    assign w_handshake = cmd_valid && cmd_ready;
    assign w_tickClear = (r_state == ST_TICK);
    assign w_inExec    = (r_state == ST_EXEC);

    always_comb begin
        w_legal = 1'b0;
        case (r_op)
            OP_ENQ:      w_legal = !w_full && !w_resident;
            OP_DEQ:      w_legal = !w_empty;
            OP_REMOVE:   w_legal = w_resident;
            OP_SETSTATE: w_legal = 1'b1;
            default:     w_legal = 1'b0;
        endcase
    end

    assign w_doEnq = w_inExec && w_legal && (r_op == OP_ENQ);
    assign w_doDeq = w_inExec && w_legal && (r_op == OP_DEQ);
    assign w_doRem = w_inExec && w_legal && (r_op == OP_REMOVE);
    assign w_doSet = w_inExec && (r_op == OP_SETSTATE);

    // A pending tick outranks a waiting command; cmd_ready already reflects that.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_tickPend) begin
                    w_stateNext = ST_TICK;
                end else if (cmd_valid) begin
                    w_stateNext = ST_EXEC;
                end
            end
            ST_EXEC:   w_stateNext = ST_SETTLE;
            ST_SETTLE: w_stateNext = ST_RESP;
            ST_RESP:   w_stateNext = ST_IDLE;
            ST_TICK:   w_stateNext = ST_IDLE;
            default:   w_stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op   <= OP_ENQ;
            r_tid  <= '0;
            r_info <= '0;
        end else if (w_handshake) begin
            r_op   <= CmdOp'(cmd_op);
            r_tid  <= cmd_tid;
            r_info <= cmd_info;
        end
    end

    // Response fields are frozen at the end of EXEC; a DEQ reports the head
    // cell as it stood while the dequeue strobe was on the array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err     <= 1'b0;
            r_rspTid  <= '0;
            r_rspInfo <= '0;
        end else if (w_inExec) begin
            r_err <= !w_legal;
            if (w_doDeq) begin
                r_rspTid  <= head_tid;
                r_rspInfo <= head_info;
            end else begin
                r_rspTid  <= r_tid;
                r_rspInfo <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_doEnq) begin
            r_count <= r_count + 1'b1;
        end else if (w_doDeq || w_doRem) begin
            r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tidMap <= '0;
        end else if (w_doEnq) begin
            r_tidMap[r_tid] <= 1'b1;
        end else if (w_doDeq) begin
            r_tidMap[head_tid] <= 1'b0;
        end else if (w_doRem) begin
            r_tidMap[r_tid] <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act <= 1'b0;
        end else if (w_doSet) begin
            r_act <= r_info[0];
        end
    end

    assign q_enqueue = w_doEnq;
    assign q_dequeue = w_doDeq;
    assign q_remove  = w_doRem;
    assign q_tick    = (r_state == ST_TICK) && r_act;
    assign q_act     = r_act;
    assign q_blk     = !r_act;
    assign q_tid     = r_tid;
    assign q_data    = r_info;

    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_err   = (r_state == ST_RESP) && r_err;
    assign rsp_tid   = r_rspTid;
    assign rsp_info  = r_rspInfo;

    assign count = r_count;
    assign full  = w_full;
    assign empty = w_empty;

endmodule

// File: tb/tb_sr_queue_ctrl.sv
// Bench for sr_queue_ctrl: directed scenarios followed by random commands,
// all checked against a transaction-level model of the queue array contents.
`timescale 1ns/1ps
module tb_sr_queue_ctrl;

    localparam int DEPTH    = 8;
    localparam int TID_W    = 4;
    localparam int INFO_W   = 32;
    localparam int TICK_DIV = 4;

    localparam logic [1:0] OP_ENQ      = 2'b00;
    localparam logic [1:0] OP_DEQ      = 2'b01;
    localparam logic [1:0] OP_REMOVE   = 2'b10;
    localparam logic [1:0] OP_SETSTATE = 2'b11;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = '0;
    logic [TID_W-1:0]  cmd_tid = '0;
    logic [INFO_W-1:0] cmd_info = '0;
    logic              q_enqueue, q_dequeue, q_remove, q_tick, q_act, q_blk;
    logic [TID_W-1:0]  q_tid;
    logic [INFO_W-1:0] q_data;
    logic [TID_W-1:0]  head_tid = '0;
    logic [INFO_W-1:0] head_info = '0;
    logic              rsp_valid, rsp_err;
    logic [TID_W-1:0]  rsp_tid;
    logic [INFO_W-1:0] rsp_info;
    logic [3:0]        count;
    logic              full, empty;

    sr_queue_ctrl #(
        .DEPTH    (DEPTH),
        .TID_W    (TID_W),
        .INFO_W   (INFO_W),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_tid   (cmd_tid),
        .cmd_info  (cmd_info),
        .q_enqueue (q_enqueue),
        .q_dequeue (q_dequeue),
        .q_remove  (q_remove),
        .q_tick    (q_tick),
        .q_act     (q_act),
        .q_blk     (q_blk),
        .q_tid     (q_tid),
        .q_data    (q_data),
        .head_tid  (head_tid),
        .head_info (head_info),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_tid   (rsp_tid),
        .rsp_info  (rsp_info),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TID_W-1:0]  tid;
        logic [INFO_W-1:0] info;
    } Entry;

    Entry modelQ[$];
    logic modelAct = 1'b0;
    int   checkCount = 0;
    int   errorCount = 0;
    int   cyc = 0;
    int   hsCyc = 0;
    int   lastTickCyc = -1;
    logic monitorOn = 1'b0;

    // Edges since reset release; the prescaler phase follows from this alone.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    function automatic int findTid(input logic [TID_W-1:0] t);
        for (int i = 0; i < modelQ.size(); i++) begin
            if (modelQ[i].tid == t) return i;
        end
        return -1;
    endfunction

    task automatic checkResetValues(input string tag);
        checkOutput({tag, ".cmd_ready"}, cmd_ready, 1);
        checkOutput({tag, ".empty"}, empty, 1);
        checkOutput({tag, ".full"}, full, 0);
        checkOutput({tag, ".count"}, count, 0);
        checkOutput({tag, ".q_act"}, q_act, 0);
        checkOutput({tag, ".q_blk"}, q_blk, 1);
        checkOutput({tag, ".strobes"}, {q_enqueue, q_dequeue, q_remove, q_tick}, 0);
        checkOutput({tag, ".rsp"}, {rsp_valid, rsp_err, rsp_tid, rsp_info}, 0);
        checkOutput({tag, ".q_bus"}, {q_tid, q_data}, 0);
    endtask

    // Entered at a negedge with the controller quiet; returns at the RESP negedge.
    task automatic applyStimulus(input logic [1:0] op, input logic [TID_W-1:0] tid, input logic [INFO_W-1:0] info);
        int                waitCyc;
        int                idx;
        logic              legal;
        logic [TID_W-1:0]  expTid;
        logic [INFO_W-1:0] expInfo;
        Entry              e;
        idx = findTid(tid);
        case (op)
            OP_ENQ:    legal = (modelQ.size() < DEPTH) && (idx < 0);
            OP_DEQ:    legal = (modelQ.size() > 0);
            OP_REMOVE: legal = (idx >= 0);
            default:   legal = 1'b1;
        endcase
        if (modelQ.size() > 0) begin
            head_tid  = modelQ[0].tid;
            head_info = modelQ[0].info;
        end else begin
            head_tid  = TID_W'($urandom);
            head_info = $urandom;
        end
        expTid  = tid;
        expInfo = '0;
        if (op == OP_DEQ && legal) begin
            expTid  = modelQ[0].tid;
            expInfo = modelQ[0].info;
        end
        cmd_op    = op;
        cmd_tid   = tid;
        cmd_info  = info;
        cmd_valid = 1'b1;
        waitCyc   = 0;
        while (!cmd_ready && waitCyc < 16) begin
            @(negedge clk);
            waitCyc++;
        end
        if (!cmd_ready) begin
            checkOutput("handshakeTimeout", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        @(negedge clk);
        hsCyc     = cyc;
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_tid   = TID_W'($urandom);
        cmd_info  = $urandom;
        checkOutput("execEnq", q_enqueue, (op == OP_ENQ) && legal);
        checkOutput("execDeq", q_dequeue, (op == OP_DEQ) && legal);
        checkOutput("execRemove", q_remove, (op == OP_REMOVE) && legal);
        checkOutput("execTid", q_tid, tid);
        checkOutput("execData", q_data, info);
        if (legal) begin
            case (op)
                OP_ENQ: begin
                    e.tid  = tid;
                    e.info = info;
                    modelQ.push_back(e);
                end
                OP_DEQ:    void'(modelQ.pop_front());
                OP_REMOVE: modelQ.delete(idx);
                default:   modelAct = info[0];
            endcase
        end
        @(negedge clk);
        checkOutput("settleQuiet", {q_enqueue, q_dequeue, q_remove, rsp_valid}, 0);
        @(negedge clk);
        checkOutput("rspValid", rsp_valid, 1);
        checkOutput("rspErr", rsp_err, !legal);
        if (!(op == OP_DEQ && !legal)) begin
            checkOutput("rspTid", rsp_tid, expTid);
            checkOutput("rspInfo", rsp_info, expInfo);
        end
        checkOutput("count", count, modelQ.size());
        checkOutput("full", full, modelQ.size() == DEPTH);
        checkOutput("empty", empty, modelQ.size() == 0);
        checkOutput("q_act", q_act, modelAct);
        checkOutput("q_blk", q_blk, !modelAct);
    endtask

    always @(negedge clk) begin
        if (monitorOn && rst_n) begin
            checkOutput("actBlkExcl", q_act ^ q_blk, 1);
            if (q_tick) begin
                lastTickCyc = cyc;
                if (!modelAct) checkOutput("tickWhileBlocked", q_tick, 0);
            end
            if ($countones({q_enqueue, q_dequeue, q_remove, q_tick}) > 1)
                checkOutput("strobeExcl", $countones({q_enqueue, q_dequeue, q_remove, q_tick}), 1);
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not reach its end");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   waitCyc;
        int   wrapCyc;
        logic gotTick;
        logic [1:0]        rOp;
        logic [TID_W-1:0]  rTid;
        logic [INFO_W-1:0] rInfo;

        repeat (3) @(negedge clk);
        checkResetValues("reset");
        rst_n = 1'b1;
        monitorOn = 1'b1;
        @(negedge clk);

        applyStimulus(OP_ENQ, 4'd3, 32'h10);
        applyStimulus(OP_ENQ, 4'd3, 32'h55);
        applyStimulus(OP_SETSTATE, 4'd0, 32'h1);

        gotTick = 1'b0;
        waitCyc = 0;
        while (!gotTick && waitCyc < 20) begin
            @(negedge clk);
            if (q_tick) gotTick = 1'b1;
            waitCyc++;
        end
        checkOutput("tickSeen", gotTick, 1);
        waitCyc = 0;
        do begin
            @(negedge clk);
            waitCyc++;
        end while ((cyc % TICK_DIV) != 0 && waitCyc < 20);
        wrapCyc = cyc;
        checkOutput("readyOnWrap", cmd_ready, 0);
        applyStimulus(OP_ENQ, 4'd4, 32'h44);
        checkOutput("tickFirst", lastTickCyc, wrapCyc + 1);
        checkOutput("enqAfterTick", hsCyc, wrapCyc + 3);

        // Reset asserted in the middle of an EXEC cycle.
        @(negedge clk);
        cmd_op = OP_ENQ; cmd_tid = 4'd7; cmd_info = 32'h77; cmd_valid = 1'b1;
        waitCyc = 0;
        while (!cmd_ready && waitCyc < 16) begin
            @(negedge clk);
            waitCyc++;
        end
        checkOutput("preResetReady", cmd_ready, 1);
        @(posedge clk);
        #1;
        checkOutput("preResetEnq", q_enqueue, 1);
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        modelQ.delete();
        modelAct = 1'b0;
        #1;
        checkResetValues("midExecReset");
        @(negedge clk);
        checkOutput("noRspInReset", rsp_valid, 0);
        rst_n = 1'b1;
        #1;
        checkOutput("readyAfterRelease", cmd_ready, 1);
        @(negedge clk);

        for (int i = 0; i < DEPTH; i++) applyStimulus(OP_ENQ, TID_W'(i), 32'h100 + i);
        applyStimulus(OP_ENQ, 4'd8, 32'h88);
        applyStimulus(OP_REMOVE, 4'd9, 32'h0);
        applyStimulus(OP_REMOVE, 4'd3, 32'h0);
        applyStimulus(OP_ENQ, 4'd3, 32'h33);
        for (int i = 0; i < DEPTH; i++) applyStimulus(OP_DEQ, 4'd0, 32'h0);
        applyStimulus(OP_DEQ, 4'd1, 32'h0);
        applyStimulus(OP_ENQ, 4'd5, 32'h22);
        applyStimulus(OP_DEQ, 4'd0, 32'h0);

        for (int n = 0; n < 200; n++) begin
            rOp   = 2'($urandom_range(0, 3));
            rTid  = TID_W'($urandom);
            rInfo = $urandom;
            if (rOp == OP_REMOVE && modelQ.size() > 0 && $urandom_range(0, 1) == 1)
                rTid = modelQ[$urandom_range(0, modelQ.size() - 1)].tid;
            applyStimulus(rOp, rTid, rInfo);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(negedge clk);
        end

        monitorOn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
